// File: rtl/ysyx_23060042_seq_pkg.sv
// Shared types for the multi-cycle control sequencer: FSM state encoding
// and the halt reason codes reported on halt_code.
package ysyx_23060042_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    IWAIT  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    MWAIT  = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seq_state_e;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

endpackage

// File: rtl/ysyx_23060042_seq_perf.sv
// Free-running performance counters: cycles since reset and retired
// instructions. Both wrap modulo 2^CNT_W.
module ysyx_23060042_seq_perf #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Count every non-reset cycle, and every retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060042_seq.sv
// Multi-cycle control sequencer for the RV32E datapath. Handshakes imem and
// dmem, then strobes IR/PC/regfile enables once per instruction; halts on
// ebreak, illegal opcode or memory timeout.
// Optional: define YSYX_SEQ_PERF_CNT_EN to build the cycle/instret counters;
// otherwise both counter ports read 0.
module ysyx_23060042_seq
  import ysyx_23060042_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  output logic             dmem_req_valid,
  output logic             dmem_req_we,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_reg_we,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             ir_wen,
  output logic             pc_wen,
  output logic             reg_wen,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Watchdog trips on the cycle where it has already counted TIMEOUT_CYC-1
  // idle wait cycles, i.e. the TIMEOUT_CYC-th cycle spent waiting.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  seq_state_e  state;
  logic [1:0]  code_q;
  logic [15:0] wdog;
  logic        st_q;   // decoded store, captured in DECODE
  logic        rwe_q;  // decoded rd write, captured in DECODE

  // Sequencer FSM with inline watchdog; response beats the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      code_q <= HALT_EBREAK;
      wdog   <= '0;
      st_q   <= 1'b0;
      rwe_q  <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_req_ready) begin
          state <= IWAIT;
          wdog  <= '0;
        end
        IWAIT: begin
          if (imem_rsp_valid) begin
            state <= DECODE;
            wdog  <= '0;
          end else if (wdog == WD_LAST) begin
            state  <= HALT;
            code_q <= HALT_TIMEOUT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DECODE: begin
          st_q  <= dec_store;
          rwe_q <= dec_reg_we;
          if (dec_illegal) begin
            state  <= HALT;
            code_q <= HALT_ILLEGAL;
          end else if (dec_ebreak) begin
            state  <= HALT;
            code_q <= HALT_EBREAK;
          end else if (dec_load || dec_store) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: if (dmem_req_ready) begin
          state <= MWAIT;
          wdog  <= '0;
        end
        MWAIT: begin
          if (dmem_rsp_valid) begin
            state <= WB;
            wdog  <= '0;
          end else if (wdog == WD_LAST) begin
            state  <= HALT;
            code_q <= HALT_TIMEOUT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes decode from registered state; all are held low while in reset.
  assign imem_req_valid = ~rst & (state == FETCH);
  assign dmem_req_valid = ~rst & (state == MEM);
  assign dmem_req_we    = dmem_req_valid & st_q;
  assign ir_wen         = ~rst & (state == IWAIT) & imem_rsp_valid;
  assign pc_wen         = ~rst & (state == WB);
  assign reg_wen        = pc_wen & rwe_q & ~st_q;
  assign retire         = pc_wen;
  assign halted         = (state == HALT);
  assign halt_code      = code_q;

`ifdef YSYX_SEQ_PERF_CNT_EN
  ysyx_23060042_seq_perf #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060042_seq.sv
// Directed bench for the control sequencer. One input vector per cycle,
// outputs compared half a cycle after each rising edge.
module tb_ysyx_23060042_seq;

  localparam int CNT_W = 64;
`ifdef YSYX_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // input vector bits
  localparam logic [8:0] IRDY = 9'h100, IRSP = 9'h080, DRDY = 9'h040,
                         DRSP = 9'h020, LD   = 9'h010, ST   = 9'h008,
                         RWE  = 9'h004, EBK  = 9'h002, ILL  = 9'h001,
                         NONE = 9'h000;
  // output vector bits
  localparam logic [7:0] O_IREQ = 8'h80, O_DREQ = 8'h40, O_WE  = 8'h20,
                         O_IR   = 8'h10, O_PC   = 8'h08, O_REG = 8'h04,
                         O_RET  = 8'h02, O_HLT  = 8'h01, O_0   = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid;
  logic dec_load, dec_store, dec_reg_we, dec_ebreak, dec_illegal;
  logic ir_wen, pc_wen, reg_wen, retire, halted;
  logic [1:0] halt_code;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060042_seq #(.TIMEOUT_CYC(8), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dec_load       (dec_load),
    .dec_store      (dec_store),
    .dec_reg_we     (dec_reg_we),
    .dec_ebreak     (dec_ebreak),
    .dec_illegal    (dec_illegal),
    .ir_wen         (ir_wen),
    .pc_wen         (pc_wen),
    .reg_wen        (reg_wen),
    .retire         (retire),
    .halted         (halted),
    .halt_code      (halt_code),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  assign outs = {imem_req_valid, dmem_req_valid, dmem_req_we, ir_wen,
                 pc_wen, reg_wen, retire, halted};

  // One cycle: drive inputs after the falling edge, check outputs, release rst.
  task automatic step(input string tag, input logic [8:0] in, input logic [7:0] exp);
    @(negedge clk);
    rst = 1'b0;
    {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid,
     dec_load, dec_store, dec_reg_we, dec_ebreak, dec_illegal} = in;
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold rst across one rising edge with idle inputs; check the reset state.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid,
     dec_load, dec_store, dec_reg_we, dec_ebreak, dec_illegal} = '0;
    @(negedge clk);
    #1;
    checks++;
    assert (outs === O_0) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, outs, O_0);
    end
    chk({tag, "_code"}, 64'(halt_code), 64'd0);
    chk({tag, "_cyc"}, 64'(cycle_cnt), 64'd0);
    chk({tag, "_ret"}, 64'(instret_cnt), 64'd0);
  endtask

  initial begin
    {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid,
     dec_load, dec_store, dec_reg_we, dec_ebreak, dec_illegal} = '0;
    do_reset("reset0");

    // addi then ebreak, zero-wait memories
    step("alu_fetch",  IRDY,       O_IREQ);            // cycle 1
    step("alu_iwait",  IRSP,       O_IR);              // cycle 2
    step("alu_dec",    RWE,        O_0);               // cycle 3
    step("alu_wb",     RWE,        O_PC|O_REG|O_RET);  // cycle 4
    step("ebk_fetch",  IRDY,       O_IREQ);            // cycle 5
    step("ebk_iwait",  IRSP,       O_IR);              // cycle 6
    step("ebk_dec",    EBK,        O_0);               // cycle 7
    step("ebk_halt",   NONE,       O_HLT);             // cycle 8
    chk("ebk_code", 64'(halt_code), 64'd0);
    chk("ebk_cyc",  64'(cycle_cnt),   PERF ? 64'd7 : 64'd0);
    chk("ebk_ret",  64'(instret_cnt), PERF ? 64'd1 : 64'd0);
    step("halt_stray", IRDY|IRSP|DRDY|DRSP|RWE, O_HLT);
    chk("halt_stray_code", 64'(halt_code), 64'd0);

    // load: 3-cycle fetch stall, dmem response 5 cycles late -> 14 cycles
    do_reset("reset1");
    for (int i = 0; i < 3; i++) step("ld_fstall", NONE, O_IREQ);
    step("ld_fetch",   IRDY,         O_IREQ);
    step("ld_iwait",   IRSP,         O_IR);
    step("ld_dec",     LD|RWE,       O_0);
    step("ld_mem",     DRDY|LD|RWE,  O_DREQ);
    for (int i = 0; i < 5; i++) step("ld_mwait", LD|RWE, O_0);
    step("ld_rsp",     DRSP|LD|RWE,  O_0);
    step("ld_wb",      LD|RWE,       O_PC|O_REG|O_RET);  // cycle 14
    step("ld_next",    NONE,         O_IREQ);

    // store with dec_reg_we=1: we=1 in MEM, no reg_wen in WB
    step("st_fetch",   IRDY,         O_IREQ);
    step("st_iwait",   IRSP,         O_IR);
    step("st_dec",     ST|RWE,       O_0);
    step("st_mstall",  ST|RWE,       O_DREQ|O_WE);
    step("st_mem",     DRDY|ST|RWE,  O_DREQ|O_WE);
    step("st_mwait",   DRSP|ST|RWE,  O_0);
    step("st_wb",      ST|RWE,       O_PC|O_RET);
    step("st_next",    NONE,         O_IREQ);

    // illegal + ebreak together: illegal wins, no commit
    step("ill_fetch",  IRDY,         O_IREQ);
    step("ill_iwait",  IRSP,         O_IR);
    step("ill_dec",    ILL|EBK|RWE,  O_0);
    step("ill_halt",   RWE,          O_HLT);
    chk("ill_code", 64'(halt_code), 64'd1);
    step("ill_halt2",  IRDY|IRSP,    O_HLT);

    // imem timeout: long FETCH stall is not counted, 8 IWAIT cycles halt
    do_reset("reset2");
    for (int i = 0; i < 10; i++) step("to_fstall", NONE, O_IREQ);
    step("to_fetch",   IRDY,         O_IREQ);
    for (int i = 0; i < 8; i++) step("to_iwait", NONE, O_0);
    step("to_halt",    NONE,         O_HLT);
    chk("to_code", 64'(halt_code), 64'd2);
    step("to_stray",   IRSP|DRSP,    O_HLT);
    chk("to_stray_code", 64'(halt_code), 64'd2);

    // response on the 8th IWAIT cycle beats the timeout
    do_reset("reset3");
    step("late_fetch", IRDY,         O_IREQ);
    for (int i = 0; i < 7; i++) step("late_iwait", NONE, O_0);
    step("late_rsp",   IRSP,         O_IR);
    step("late_dec",   RWE,          O_0);
    step("late_wb",    RWE,          O_PC|O_REG|O_RET);

    // dmem timeout in MWAIT
    step("dto_fetch",  IRDY,         O_IREQ);
    step("dto_iwait",  IRSP,         O_IR);
    step("dto_dec",    LD,           O_0);
    step("dto_mem",    DRDY|LD,      O_DREQ);
    for (int i = 0; i < 8; i++) step("dto_mwait", LD, O_0);
    step("dto_halt",   LD,           O_HLT);
    chk("dto_code", 64'(halt_code), 64'd2);

    // rst during MWAIT returns to FETCH with counters cleared
    do_reset("reset4");
    step("mr_fetch",   IRDY,         O_IREQ);
    step("mr_iwait",   IRSP,         O_IR);
    step("mr_dec",     LD|RWE,       O_0);
    step("mr_mem",     DRDY|LD|RWE,  O_DREQ);
    step("mr_mwait",   LD|RWE,       O_0);
    do_reset("mr_rst");
    step("mr_refetch", NONE,         O_IREQ);
    chk("mr_cyc", 64'(cycle_cnt),   64'd0);
    chk("mr_ret", 64'(instret_cnt), 64'd0);
    step("mr_idle",    NONE,         O_IREQ);
    chk("mr_cyc1", 64'(cycle_cnt),  PERF ? 64'd1 : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
